// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator, rx synchroniser, 16-deep show-ahead byte FIFO, idle timeout.
// FIFO data visible 1 cycle after push; full FIFO drops new bytes (sticky overflow) unless popped that cycle. Glitch filter: UART_RX_CTRL_GLITCH_FILTER_EN.
module uart_rx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int DIV_W        = 16,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_W-1:0]     divisor,
    input  logic                 rx_pin,
    output logic                 rx_sync,
    output logic                 s_tick,
    input  logic [DATA_BITS-1:0] rx_data_in,
    input  logic                 rx_done_tick_in,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ADDR_W:0]      fifo_count,
    output logic                 overflow,
    input  logic                 clr_overflow,
    output logic                 timeout_tick
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int TO_THRESH = TIMEOUT_BITS * 16;
    localparam int TO_W      = $clog2(TO_THRESH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_THRESH - 1);

    typedef enum logic [1:0] {TO_IDLE, TO_COUNT, TO_DONE} to_state_t;

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] baud_lim;

    // >= compare lets a smaller divisor take effect without waiting for a wrap
    assign baud_lim = (divisor == '0) ? '0 : divisor - DIV_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            s_tick   <= 1'b0;
        end else if (!enable) begin
            baud_cnt <= '0;
            s_tick   <= 1'b0;
        end else if (baud_cnt >= baud_lim) begin
            baud_cnt <= '0;
            s_tick   <= 1'b1;
        end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
            s_tick   <= 1'b0;
        end
    end

    // ---------------- rx synchroniser ----------------
    logic sync1, sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_pin;
            sync2 <= sync1;
        end
    end

`ifdef UART_RX_CTRL_GLITCH_FILTER_EN
    logic sync3, filt;

    // majority over the three most recent synchronised samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync3 <= 1'b1;
            filt  <= 1'b1;
        end else begin
            sync3 <= sync2;
            filt  <= (sync1 & sync2) | (sync1 & sync3) | (sync2 & sync3);
        end
    end

    assign rx_sync = filt;
`else
    assign rx_sync = sync2;
`endif

    // ---------------- byte FIFO ----------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr, rd_ptr;
    logic                 push_req, push, pop, full, going_empty;

    assign m_valid     = (fifo_count != '0);
    assign full        = (fifo_count == (ADDR_W+1)'(DEPTH));
    assign pop         = m_valid & m_ready;
    assign push_req    = rx_done_tick_in & enable;
    assign push        = push_req & (~full | pop);
    assign going_empty = pop & ~push & (fifo_count == (ADDR_W+1)'(1));
    assign m_data      = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (ADDR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (ADDR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // set wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (push_req & full & ~pop)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end

    // ---------------- idle timeout ----------------
    to_state_t       to_state, to_state_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic            tick_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_state     <= TO_IDLE;
            to_cnt       <= '0;
            timeout_tick <= 1'b0;
        end else begin
            to_state     <= to_state_n;
            to_cnt       <= to_cnt_n;
            timeout_tick <= tick_n;
        end
    end

    always_comb begin
        to_state_n = to_state;
        to_cnt_n   = to_cnt;
        tick_n     = 1'b0;
        if (!m_valid || going_empty) begin
            to_state_n = TO_IDLE;
            to_cnt_n   = '0;
        end else begin
            case (to_state)
                TO_IDLE: begin
                    to_state_n = TO_COUNT;
                    to_cnt_n   = '0;
                end
                TO_COUNT: begin
                    if (push) begin
                        to_cnt_n = '0;
                    end else if (s_tick) begin
                        if (to_cnt == TO_LAST) begin
                            to_state_n = TO_DONE;
                            to_cnt_n   = '0;
                            tick_n     = 1'b1;
                        end else begin
                            to_cnt_n = to_cnt + TO_W'(1);
                        end
                    end
                end
                TO_DONE: begin
                    if (push) begin
                        to_state_n = TO_COUNT;
                        to_cnt_n   = '0;
                    end
                end
                default: begin
                    to_state_n = TO_IDLE;
                    to_cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud ticks, synchroniser, FIFO, overflow, timeout, async reset.
module tb_uart_rx_ctrl;
    localparam int DATA_BITS = 8;
    localparam int DIV_W     = 16;
    localparam int ADDR_W    = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [DIV_W-1:0]     divisor;
    logic                 rx_pin;
    logic                 rx_sync;
    logic                 s_tick;
    logic [DATA_BITS-1:0] rx_data_in;
    logic                 rx_done_tick_in;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [ADDR_W:0]      fifo_count;
    logic                 overflow;
    logic                 clr_overflow;
    logic                 timeout_tick;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W), .ADDR_W(ADDR_W), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
        .rx_pin(rx_pin), .rx_sync(rx_sync), .s_tick(s_tick),
        .rx_data_in(rx_data_in), .rx_done_tick_in(rx_done_tick_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow),
        .timeout_tick(timeout_tick)
    );

    task automatic push_byte(input logic [7:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        rx_data_in      = d;
        rx_done_tick_in = 1'b1;
        m_ready         = rdy;
        clr_overflow    = clr;
        @(posedge clk);
        #1;
        rx_done_tick_in = 1'b0;
        m_ready         = 1'b0;
        clr_overflow    = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({rx_sync, s_tick, m_valid, m_data, fifo_count, overflow, timeout_tick} !== {1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got sync=%b tick=%b vld=%b dat=%h cnt=%0d ovf=%b to=%b want 1 0 0 00 0 0 0",
                     rx_sync, s_tick, m_valid, m_data, fifo_count, overflow, timeout_tick);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_baud;
        @(negedge clk);
        divisor = 16'd5;
        enable  = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (s_tick !== (i == 5)) begin
                n_err++;
                $display("FAIL baud_div5 cyc%0d: got %b want %b", i, s_tick, (i == 5));
            end
        end
        @(negedge clk);
        divisor = 16'd3;
        for (int i = 10; i <= 16; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (s_tick !== (i == 10 || i == 13 || i == 16)) begin
                n_err++;
                $display("FAIL baud_div3 cyc%0d: got %b want %b", i, s_tick, (i == 10 || i == 13 || i == 16));
            end
        end
        @(negedge clk);
        divisor = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (s_tick !== 1'b1) begin
                n_err++;
                $display("FAIL baud_div0 cyc%0d: got %b want 1", i, s_tick);
            end
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (s_tick !== 1'b0) begin
            n_err++;
            $display("FAIL baud_disabled: got %b want 0", s_tick);
        end
        @(negedge clk);
        enable  = 1'b1;
        divisor = 16'd4;
    endtask

    task automatic test_sync;
`ifdef UART_RX_CTRL_GLITCH_FILTER_EN
        @(negedge clk);
        rx_pin = 1'b0;
        @(negedge clk);
        rx_pin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rx_sync !== 1'b1) begin
                n_err++;
                $display("FAIL sync_glitch cyc%0d: got %b want 1", i, rx_sync);
            end
        end
        @(negedge clk);
        rx_pin = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rx_sync !== (i != 3)) begin
                n_err++;
                $display("FAIL sync_fall cyc%0d: got %b want %b", i, rx_sync, (i != 3));
            end
        end
        @(negedge clk);
        rx_pin = 1'b1;
        for (int i = 4; i <= 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rx_sync !== (i == 6)) begin
                n_err++;
                $display("FAIL sync_rise cyc%0d: got %b want %b", i, rx_sync, (i == 6));
            end
        end
`else
        @(negedge clk);
        rx_pin = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rx_sync !== (i != 2)) begin
                n_err++;
                $display("FAIL sync_fall cyc%0d: got %b want %b", i, rx_sync, (i != 2));
            end
        end
        @(negedge clk);
        rx_pin = 1'b1;
        for (int i = 3; i <= 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rx_sync !== (i == 4)) begin
                n_err++;
                $display("FAIL sync_rise cyc%0d: got %b want %b", i, rx_sync, (i == 4));
            end
        end
`endif
    endtask

    task automatic test_fifo;
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fifo_empty_start: got %b want 0", m_valid);
        end
        push_byte(8'hA5, 1'b0, 1'b0);
        n_cmp++;
        if ({m_valid, m_data, fifo_count} !== {1'b1, 8'hA5, 5'd1}) begin
            n_err++;
            $display("FAIL fifo_first: got vld=%b dat=%h cnt=%0d want 1 a5 1", m_valid, m_data, fifo_count);
        end
        push_byte(8'h3C, 1'b0, 1'b0);
        n_cmp++;
        if ({m_valid, m_data, fifo_count} !== {1'b1, 8'hA5, 5'd2}) begin
            n_err++;
            $display("FAIL fifo_second: got vld=%b dat=%h cnt=%0d want 1 a5 2", m_valid, m_data, fifo_count);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({m_valid, m_data, fifo_count} !== {1'b1, 8'h3C, 5'd1}) begin
            n_err++;
            $display("FAIL fifo_pop1: got vld=%b dat=%h cnt=%0d want 1 3c 1", m_valid, m_data, fifo_count);
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        n_cmp++;
        if ({m_valid, fifo_count} !== {1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL fifo_pop2: got vld=%b cnt=%0d want 0 0", m_valid, fifo_count);
        end
        enable = 1'b0;
        push_byte(8'h77, 1'b0, 1'b0);
        n_cmp++;
        if ({m_valid, fifo_count} !== {1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL fifo_push_disabled: got vld=%b cnt=%0d want 0 0", m_valid, fifo_count);
        end
        enable = 1'b1;
    endtask

    task automatic test_overflow;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1'b0, 1'b0);
        n_cmp++;
        if ({fifo_count, m_data, overflow} !== {5'd16, 8'h10, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_full: got cnt=%0d dat=%h ovf=%b want 16 10 0", fifo_count, m_data, overflow);
        end
        push_byte(8'hEE, 1'b0, 1'b0);
        n_cmp++;
        if ({fifo_count, m_data, overflow} !== {5'd16, 8'h10, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_drop: got cnt=%0d dat=%h ovf=%b want 16 10 1", fifo_count, m_data, overflow);
        end
        @(negedge clk);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        push_byte(8'hED, 1'b0, 1'b1);
        n_cmp++;
        if ({fifo_count, overflow} !== {5'd16, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_set_wins: got cnt=%0d ovf=%b want 16 1", fifo_count, overflow);
        end
        @(negedge clk);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        push_byte(8'hEF, 1'b1, 1'b0);
        n_cmp++;
        if ({fifo_count, m_data, overflow} !== {5'd16, 8'h11, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_push_pop: got cnt=%0d dat=%h ovf=%b want 16 11 0", fifo_count, m_data, overflow);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? 8'(8'h11 + i) : 8'hEF;
            n_cmp++;
            if ({m_valid, m_data} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL ovf_drain%0d: got vld=%b dat=%h want 1 %h", i, m_valid, m_data, e);
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        n_cmp++;
        if ({m_valid, fifo_count} !== {1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL ovf_drained: got vld=%b cnt=%0d want 0 0", m_valid, fifo_count);
        end
    endtask

    task automatic test_timeout;
        int ticks, pulses, at_pulse;
        // one byte, no activity: exactly one pulse after 64 counted ticks
        push_byte(8'h55, 1'b0, 1'b0);
        ticks = 0; pulses = 0; at_pulse = -1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (timeout_tick === 1'b1) begin
                pulses++;
                if (pulses == 1) at_pulse = ticks;
            end
            if (s_tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (pulses != 1 || at_pulse != 64) begin
            n_err++;
            $display("FAIL timeout_single: got pulses=%0d at_tick=%0d want 1 at 64", pulses, at_pulse);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        // a push at tick 30 restarts the count
        push_byte(8'h66, 1'b0, 1'b0);
        ticks = 0; pulses = 0; at_pulse = -1;
        for (int c = 0; c < 400 && ticks < 30; c++) begin
            @(posedge clk); #1;
            if (timeout_tick === 1'b1) pulses++;
            if (s_tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks != 30) begin
            n_err++;
            $display("FAIL timeout_wait30: got %0d ticks want 30 within budget", ticks);
        end
        push_byte(8'h67, 1'b0, 1'b0);
        ticks = (s_tick === 1'b1) ? 1 : 0;
        if (timeout_tick === 1'b1) pulses++;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (timeout_tick === 1'b1) begin
                pulses++;
                if (pulses == 1) at_pulse = ticks;
            end
            if (s_tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (pulses != 1 || at_pulse != 64) begin
            n_err++;
            $display("FAIL timeout_restart: got pulses=%0d at_tick=%0d want 1 at 64", pulses, at_pulse);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        // pop to empty before the threshold: no pulse
        push_byte(8'h68, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        pulses = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (timeout_tick === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || fifo_count !== 5'd0) begin
            n_err++;
            $display("FAIL timeout_emptied: got pulses=%0d cnt=%0d want 0 0", pulses, fifo_count);
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        divisor = 16'd0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1'b0, 1'b0);
        rx_pin = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({fifo_count, rx_sync, s_tick} !== {5'd5, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_pre: got cnt=%0d sync=%b tick=%b want 5 0 1", fifo_count, rx_sync, s_tick);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rx_sync, s_tick, m_valid, m_data, fifo_count, overflow, timeout_tick} !== {1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_async: got sync=%b tick=%b vld=%b dat=%h cnt=%0d ovf=%b to=%b want 1 0 0 00 0 0 0",
                     rx_sync, s_tick, m_valid, m_data, fifo_count, overflow, timeout_tick);
        end
        rx_pin = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({m_valid, fifo_count} !== {1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL rst_after: got vld=%b cnt=%0d want 0 0", m_valid, fifo_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        enable          = 1'b0;
        divisor         = 16'd5;
        rx_pin          = 1'b1;
        rx_data_in      = '0;
        rx_done_tick_in = 1'b0;
        m_ready         = 1'b0;
        clr_overflow    = 1'b0;
        test_reset();
        test_baud();
        test_sync();
        test_fifo();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
